lb2apb: RTL and testbench

- Bridge from the local bus (LB) to APB: LB responder on the upstream side, APB initiator on the downstream side.
- Used to reach APB peripherals from LB-based masters.
- Pairs with the existing APB-to-LB bridge in loopback benches (lb2apb -> apb2lb -> register map).
- Issues exactly one APB transfer per LB request, with an optional watchdog on PREADY.

---
 rtl/lb2apb_pkg.sv | 14 +
 rtl/lb2apb.sv | 140 ++++++++++++++
 tb/tb_lb2apb.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lb2apb_pkg.sv
// Shared definitions for the local-bus to APB bridge.
// FSM state encoding and the fixed APB protection attribute.
package lb2apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [2:0] PPROT = 3'b000;

endpackage

// File: rtl/lb2apb.sv
// Local-bus responder to APB initiator: one APB transfer per LB request,
// with an optional watchdog that aborts a transfer stuck waiting on pready.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   lb_w*           LB write request (held until lb_wready pulse)
//   lb_r*           LB read request (held until lb_rvalid pulse)
//   lb_err          error flag, valid with lb_wready/lb_rvalid
//   psel..pprot     APB initiator outputs
//   prdata, pready, pslverr  APB completer responses
module lb2apb
   import lb2apb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lb_waddr,
   input  logic [DATA_W-1:0] lb_wdata,
   input  logic [STRB_W-1:0] lb_wstrb,
   input  logic              lb_wen,
   output logic              lb_wready,
   input  logic [ADDR_W-1:0] lb_raddr,
   input  logic              lb_ren,
   output logic [DATA_W-1:0] lb_rdata,
   output logic              lb_rvalid,
   output logic              lb_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic [STRB_W-1:0] pstrb,
   output logic [2:0]        pprot,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST =
      (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [STRB_W-1:0] r_pstrb;
   logic [DATA_W-1:0] r_rdata;
   logic              r_wready;
   logic              r_rvalid;
   logic              r_err;

   // Watchdog fires on the last permitted ACCESS cycle without pready.
   logic w_expire;
   assign w_expire = (TIMEOUT != 0) && (r_cnt == LAST) && !pready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
         r_rdata   <= '0;
         r_wready  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               // Write has priority; a concurrent read waits for a later IDLE.
               if (lb_wen) begin
                  r_paddr  <= lb_waddr;
                  r_pwdata <= lb_wdata;
                  r_pstrb  <= lb_wstrb;
                  r_pwrite <= 1'b1;
                  r_psel   <= 1'b1;
                  r_state  <= SETUP;
               end else if (lb_ren) begin
                  r_paddr  <= lb_raddr;
                  r_pstrb  <= '0;
                  r_pwrite <= 1'b0;
                  r_psel   <= 1'b1;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               if (pready || w_expire) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_wready  <= r_pwrite;
                  r_rvalid  <= !r_pwrite;
                  r_err     <= pready ? pslverr : 1'b1;
                  if (!r_pwrite)
                     r_rdata <= pready ? prdata : '0;
                  r_state   <= DONE;
               end else if (TIMEOUT != 0) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               // Requests still held here are not re-sampled.
               r_wready <= 1'b0;
               r_rvalid <= 1'b0;
               r_err    <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;
   assign pstrb     = r_pstrb;
   assign pprot     = PPROT;
   assign lb_rdata  = r_rdata;
   assign lb_wready = r_wready;
   assign lb_rvalid = r_rvalid;
   assign lb_err    = r_err;

endmodule

// File: tb/tb_lb2apb.sv
// Directed self-checking bench for lb2apb.
// Drives LB requests and a hand-scripted APB completer.
module tb_lb2apb;
   import lb2apb_pkg::*;

   logic        clk;
   logic        rst;
   logic [15:0] lb_waddr;
   logic [31:0] lb_wdata;
   logic [3:0]  lb_wstrb;
   logic        lb_wen;
   logic        lb_wready;
   logic [15:0] lb_raddr;
   logic        lb_ren;
   logic [31:0] lb_rdata;
   logic        lb_rvalid;
   logic        lb_err;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [15:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int n_chk = 0;
   int n_err = 0;
   int n_en;

   lb2apb #(
      .ADDR_W (16),
      .DATA_W (32),
      .TIMEOUT(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .lb_waddr (lb_waddr),
      .lb_wdata (lb_wdata),
      .lb_wstrb (lb_wstrb),
      .lb_wen   (lb_wen),
      .lb_wready(lb_wready),
      .lb_raddr (lb_raddr),
      .lb_ren   (lb_ren),
      .lb_rdata (lb_rdata),
      .lb_rvalid(lb_rvalid),
      .lb_err   (lb_err),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .pstrb    (pstrb),
      .pprot    (pprot),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic chk_st(input string tag, input state_t exp);
      chk(tag, 32'(dut.r_state), 32'(exp));
   endtask

   initial begin
      rst      = 1'b1;
      lb_waddr = '0;
      lb_wdata = '0;
      lb_wstrb = '0;
      lb_wen   = 1'b0;
      lb_raddr = '0;
      lb_ren   = 1'b0;
      prdata   = '0;
      pready   = 1'b1;
      pslverr  = 1'b0;
      tick();
      tick();

      // Reset state
      chk_st("rst_state", IDLE);
      chk("rst_psel", 32'(psel), 0);
      chk("rst_pen", 32'(penable), 0);
      chk("rst_pwrite", 32'(pwrite), 0);
      chk("rst_paddr", 32'(paddr), 0);
      chk("rst_pstrb", 32'(pstrb), 0);
      chk("rst_wready", 32'(lb_wready), 0);
      chk("rst_rvalid", 32'(lb_rvalid), 0);
      chk("rst_err", 32'(lb_err), 0);
      chk("rst_rdata", lb_rdata, 0);
      chk("pprot", 32'(pprot), 0);
      rst = 1'b0;
      tick();

      // Write, zero wait states
      lb_waddr = 16'h0010;
      lb_wdata = 32'hDEADBEEF;
      lb_wstrb = 4'hF;
      lb_wen   = 1'b1;
      tick();
      chk_st("w0_state", SETUP);
      chk("w0_psel", 32'(psel), 1);
      chk("w0_pen", 32'(penable), 0);
      chk("w0_pwrite", 32'(pwrite), 1);
      chk("w0_paddr", 32'(paddr), 32'h10);
      chk("w0_pwdata", pwdata, 32'hDEADBEEF);
      chk("w0_pstrb", 32'(pstrb), 32'hF);
      chk("w0_wready", 32'(lb_wready), 0);
      tick();
      chk_st("w1_state", ACCESS);
      chk("w1_psel", 32'(psel), 1);
      chk("w1_pen", 32'(penable), 1);
      chk("w1_paddr", 32'(paddr), 32'h10);
      chk("w1_wready", 32'(lb_wready), 0);
      tick();
      chk_st("w2_state", DONE);
      chk("w2_wready", 32'(lb_wready), 1);
      chk("w2_rvalid", 32'(lb_rvalid), 0);
      chk("w2_err", 32'(lb_err), 0);
      chk("w2_psel", 32'(psel), 0);
      chk("w2_pen", 32'(penable), 0);
      // Request deliberately still held through DONE
      tick();
      chk_st("w3_state", IDLE);
      chk("w3_wready", 32'(lb_wready), 0);
      chk("w3_psel", 32'(psel), 0);
      lb_wen = 1'b0;
      tick();
      chk_st("w4_state", IDLE);

      // Read with 3 wait states
      lb_raddr = 16'h0024;
      lb_ren   = 1'b1;
      prdata   = 32'h12345678;
      pready   = 1'b0;
      n_en     = 0;
      tick();
      chk_st("r0_state", SETUP);
      chk("r0_pwrite", 32'(pwrite), 0);
      chk("r0_pstrb", 32'(pstrb), 0);
      chk("r0_paddr", 32'(paddr), 32'h24);
      tick();
      if (penable) n_en++;
      tick();
      if (penable) n_en++;
      chk("r2_rvalid", 32'(lb_rvalid), 0);
      tick();
      if (penable) n_en++;
      tick();
      if (penable) n_en++;
      chk("r4_rvalid", 32'(lb_rvalid), 0);
      chk("r4_pstrb", 32'(pstrb), 0);
      pready = 1'b1;
      tick();
      chk("r_pen_cycles", 32'(n_en), 4);
      chk("r5_rvalid", 32'(lb_rvalid), 1);
      chk("r5_wready", 32'(lb_wready), 0);
      chk("r5_rdata", lb_rdata, 32'h12345678);
      chk("r5_err", 32'(lb_err), 0);
      lb_ren = 1'b0;
      prdata = 32'h0;
      tick();
      chk("r6_rvalid", 32'(lb_rvalid), 0);
      chk("r6_rdata_hold", lb_rdata, 32'h12345678);

      // Simultaneous write and read, both held
      lb_waddr = 16'h0030;
      lb_wdata = 32'hA5A5A5A5;
      lb_wstrb = 4'h3;
      lb_raddr = 16'h0034;
      lb_wen   = 1'b1;
      lb_ren   = 1'b1;
      prdata   = 32'hCAFEF00D;
      tick();
      chk("s0_pwrite", 32'(pwrite), 1);
      chk("s0_paddr", 32'(paddr), 32'h30);
      chk("s0_pstrb", 32'(pstrb), 32'h3);
      tick();
      tick();
      chk("s2_wready", 32'(lb_wready), 1);
      chk("s2_rvalid", 32'(lb_rvalid), 0);
      lb_wen = 1'b0;
      tick();
      chk_st("s3_state", IDLE);
      chk("s3_wready", 32'(lb_wready), 0);
      tick();
      chk_st("s4_state", SETUP);
      chk("s4_pwrite", 32'(pwrite), 0);
      chk("s4_paddr", 32'(paddr), 32'h34);
      chk("s4_pstrb", 32'(pstrb), 0);
      tick();
      tick();
      chk("s6_rvalid", 32'(lb_rvalid), 1);
      chk("s6_wready", 32'(lb_wready), 0);
      chk("s6_rdata", lb_rdata, 32'hCAFEF00D);
      lb_ren = 1'b0;
      tick();
      chk("s7_rvalid", 32'(lb_rvalid), 0);

      // Slave error on a write
      lb_waddr = 16'h0044;
      lb_wdata = 32'h00000001;
      lb_wstrb = 4'h1;
      lb_wen   = 1'b1;
      pslverr  = 1'b1;
      tick();
      tick();
      tick();
      chk("e2_wready", 32'(lb_wready), 1);
      chk("e2_err", 32'(lb_err), 1);
      lb_wen  = 1'b0;
      pslverr = 1'b0;
      tick();
      chk("e3_err", 32'(lb_err), 0);

      // Watchdog: pready stuck low
      lb_raddr = 16'h0040;
      lb_ren   = 1'b1;
      prdata   = 32'hFFFFFFFF;
      pready   = 1'b0;
      n_en     = 0;
      tick();
      chk_st("t0_state", SETUP);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (penable) n_en++;
         if (lb_rvalid) break;
      end
      chk("t_access_cycles", 32'(n_en), 8);
      chk("t_rvalid", 32'(lb_rvalid), 1);
      chk("t_err", 32'(lb_err), 1);
      chk("t_rdata", lb_rdata, 32'h0);
      lb_ren = 1'b0;
      pready = 1'b1;
      tick();
      chk_st("t_after_state", IDLE);

      // Normal request after a timeout
      lb_waddr = 16'h0050;
      lb_wdata = 32'h55AA55AA;
      lb_wstrb = 4'hC;
      lb_wen   = 1'b1;
      tick();
      tick();
      tick();
      chk("n2_wready", 32'(lb_wready), 1);
      chk("n2_err", 32'(lb_err), 0);
      lb_wen = 1'b0;
      tick();

      // Reset in ACCESS
      lb_waddr = 16'h0060;
      lb_wdata = 32'h11112222;
      lb_wstrb = 4'hF;
      lb_wen   = 1'b1;
      pready   = 1'b0;
      tick();
      tick();
      chk("x1_pen", 32'(penable), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("x_psel_async", 32'(psel), 0);
      chk("x_pen_async", 32'(penable), 0);
      chk_st("x_state_async", IDLE);
      pready = 1'b1;
      tick();
      chk("x_wready", 32'(lb_wready), 0);
      chk("x_rvalid", 32'(lb_rvalid), 0);
      lb_wen = 1'b0;
      tick();
      chk("x_wready2", 32'(lb_wready), 0);
      rst = 1'b0;
      tick();

      // Read after reset release
      lb_raddr = 16'h0070;
      lb_ren   = 1'b1;
      prdata   = 32'h0BADF00D;
      tick();
      chk("p0_psel", 32'(psel), 1);
      tick();
      tick();
      chk("p2_rvalid", 32'(lb_rvalid), 1);
      chk("p2_rdata", lb_rdata, 32'h0BADF00D);
      chk("p2_err", 32'(lb_err), 0);
      lb_ren = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "bench timeout");
   end

endmodule
